// File: rtl/bus_pkg.sv
// rtl/bus_pkg.sv - shared constants, lane state type and packet address helper
package bus_pkg;
  localparam int ID_W = 8;
  localparam logic [ID_W-1:0] BROADCAST = 8'hFF;
  localparam int PKT_MAX_W = 256;

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  // Address byte sits in the top ID_W bits of the packet; msb is pckg_sz-1.
  function automatic logic [ID_W-1:0] pkt_id(input logic [PKT_MAX_W-1:0] pkt,
                                             input logic [7:0] msb);
    return pkt[msb -: ID_W];
  endfunction
endpackage

// File: rtl/bus_lane_arb.sv
// rtl/bus_lane_arb.sv - one bus: round-robin pop from driver FIFOs, then push to addressed FIFOs
module bus_lane_arb
  import bus_pkg::*;
#(
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [drvrs-1:0]         pndng,
  input  logic [drvrs*pckg_sz-1:0] D_pop,
  output logic [drvrs-1:0]         pop,
  output logic [drvrs-1:0]         push,
  output logic [pckg_sz-1:0]       D_push
);
  localparam int SRC_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_t             state;
  logic [SRC_W-1:0]   rr;
  logic [SRC_W-1:0]   src;
  logic [SRC_W-1:0]   grant;
  logic [SRC_W-1:0]   cand;
  logic [pckg_sz-1:0] pkt;
  logic [pckg_sz-1:0] head;
  logic [ID_W-1:0]    id;
  logic [drvrs-1:0]   push_mask;

  // Walk offsets from the farthest down to rr so the closest pending driver wins.
  always_comb begin
    grant = rr;
    cand  = rr;
    for (int i = drvrs - 1; i >= 0; i--) begin
      cand = SRC_W'((int'(rr) + i) % drvrs);
      if (pndng[cand]) grant = cand;
    end
  end

  always_comb begin
    head = '0;
    for (int d = 0; d < drvrs; d++) begin
      if (grant == SRC_W'(d)) head = D_pop[d*pckg_sz +: pckg_sz];
    end
  end

  always_comb begin
    id = pkt_id(PKT_MAX_W'(pkt), 8'(pckg_sz - 1));
    push_mask = '0;
    if (id == broadcast) push_mask = ~(drvrs'(1) << src);
    else if (int'(id) < drvrs) push_mask = drvrs'(1) << id;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      rr     <= '0;
      src    <= '0;
      pkt    <= '0;
      pop    <= '0;
      push   <= '0;
      D_push <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|pndng) begin
            pop   <= drvrs'(1) << grant;
            pkt   <= head;
            src   <= grant;
            state <= POP;
          end
        end
        POP: begin
          pop    <= '0;
          D_push <= pkt;
          push   <= push_mask;
          state  <= PUSH;
        end
        PUSH: begin
          push  <= '0;
          rr    <= (src == SRC_W'(drvrs - 1)) ? '0 : src + 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: rtl/bus_gen_arbiter.sv
// rtl/bus_gen_arbiter.sv - bits independent buses, each arbitrated by its own lane
module bus_gen_arbiter
  import bus_pkg::*;
#(
  parameter int bits = 1,
  parameter int drvrs = 4,
  parameter int pckg_sz = 16,
  parameter logic [ID_W-1:0] broadcast = BROADCAST
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [bits*drvrs-1:0]         pndng,
  output logic [bits*drvrs-1:0]         push,
  output logic [bits*drvrs-1:0]         pop,
  input  logic [bits*drvrs*pckg_sz-1:0] D_pop,
  output logic [bits*drvrs*pckg_sz-1:0] D_push
);
  for (genvar b = 0; b < bits; b++) begin : g_bus
    logic [pckg_sz-1:0] lane_data;

    bus_lane_arb #(
      .drvrs(drvrs),
      .pckg_sz(pckg_sz),
      .broadcast(broadcast)
    ) u_lane (
      .clk(clk),
      .reset(reset),
      .pndng(pndng[b*drvrs +: drvrs]),
      .D_pop(D_pop[b*drvrs*pckg_sz +: drvrs*pckg_sz]),
      .pop(pop[b*drvrs +: drvrs]),
      .push(push[b*drvrs +: drvrs]),
      .D_push(lane_data)
    );

    // Every FIFO on a bus sees the same data; push selects who takes it.
    for (genvar d = 0; d < drvrs; d++) begin : g_lane
      assign D_push[(b*drvrs+d)*pckg_sz +: pckg_sz] = lane_data;
    end
  end
endmodule

// File: tb/tb_bus_gen_arbiter.sv
// tb/tb_bus_gen_arbiter.sv - scoreboard bench for bus_gen_arbiter with FIFO environment model
module tb_bus_gen_arbiter;
  localparam int DRV = 4;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           reset;
  logic [DRV-1:0] pndng;
  logic [DRV-1:0] push;
  logic [DRV-1:0] pop;
  logic [DRV*W-1:0] D_pop;
  logic [DRV*W-1:0] D_push;

  always #5 clk = ~clk;

  bus_gen_arbiter #(
    .bits(1),
    .drvrs(DRV),
    .pckg_sz(W),
    .broadcast(8'hFF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .pndng(pndng),
    .push(push),
    .pop(pop),
    .D_pop(D_pop),
    .D_push(D_push)
  );

  logic [W-1:0] fifo [DRV][$];

  // Reference model: grant one pending driver, then stay busy for two more edges.
  int cyc = 0;
  int busy = 0;
  int rr_m = 0;
  int wr = 0;
  int m_g;
  logic [W-1:0]   m_pkt;
  logic [7:0]     m_id;
  logic [DRV-1:0] m_mask;
  int             exp_drv  [256];
  int             exp_cyc  [256];
  logic [DRV-1:0] exp_mask [256];
  logic [W-1:0]   exp_pkt  [256];

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      busy = 0;
      rr_m = 0;
    end else if (busy > 0) begin
      busy--;
    end else if (pndng != '0) begin
      m_g = -1;
      for (int k = 0; k < DRV; k++)
        if (m_g < 0 && pndng[(rr_m + k) % DRV]) m_g = (rr_m + k) % DRV;
      m_pkt = D_pop[m_g*W +: W];
      m_id  = m_pkt[W-1 -: 8];
      for (int d = 0; d < DRV; d++)
        m_mask[d] = (m_id == 8'hFF) ? (d != m_g) : (int'(m_id) == d);
      exp_drv[wr % 256]  = m_g;
      exp_cyc[wr % 256]  = cyc;
      exp_mask[wr % 256] = m_mask;
      exp_pkt[wr % 256]  = m_pkt;
      wr++;
      rr_m = (m_g + 1) % DRV;
      busy = 2;
    end
  end

  int checks = 0;
  int errors = 0;
  int rd = 0;
  bit push_due = 1'b0;
  bit done = 1'b0;
  logic [DRV-1:0] due_mask;
  logic [W-1:0]   due_pkt;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("all_grants_seen", 64'(wr - rd), 64'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end else if (!reset) begin
      chk("reset_pop", 64'(pop), 64'(0));
      chk("reset_push", 64'(push), 64'(0));
      chk("reset_dpush", 64'(D_push), 64'(0));
      push_due = 1'b0;
      rd = wr;
    end else begin
      if (push_due) begin
        chk("push_mask", 64'(push), 64'(due_mask));
        chk("push_data", 64'(D_push), 64'({DRV{due_pkt}}));
        push_due = 1'b0;
      end else if (push != '0) begin
        chk("stray_push", 64'(push), 64'(0));
      end
      if (rd != wr && exp_cyc[rd % 256] == cyc) begin
        chk("pop_grant", 64'(pop), 64'(1) << exp_drv[rd % 256]);
        due_mask = exp_mask[rd % 256];
        due_pkt  = exp_pkt[rd % 256];
        push_due = 1'b1;
        rd++;
      end else if (pop != '0) begin
        chk("stray_pop", 64'(pop), 64'(0));
      end
    end
  end

  task automatic drive();
    for (int d = 0; d < DRV; d++) begin
      pndng[d] = (fifo[d].size() != 0);
      D_pop[d*W +: W] = (fifo[d].size() != 0) ? fifo[d][0] : '0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    for (int d = 0; d < DRV; d++)
      if (pop[d] && fifo[d].size() != 0) void'(fifo[d].pop_front());
    drive();
  endtask

  task automatic add(int d, logic [W-1:0] p);
    fifo[d].push_back(p);
    drive();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d;
    logic [7:0] a;
    reset = 1'b0;
    pndng = '0;
    D_pop = '0;
    fifo[0].push_back(16'h01A0);
    fifo[0].push_back(16'hFFA4);
    fifo[1].push_back(16'h00A1);
    fifo[2].push_back(16'h03A2);
    fifo[3].push_back(16'h0712);
    drive();
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();

    add(1, 16'h02AB);
    repeat (6) tick();
    add(0, 16'hFF55);
    repeat (6) tick();

    add(2, 16'h0133);
    for (int i = 0; i < 10 && pop == '0; i++) tick();
    reset = 1'b0;
    repeat (2) tick();
    add(1, 16'h0266);
    add(0, 16'h0177);
    reset = 1'b1;
    repeat (10) tick();

    repeat (400) begin
      tick();
      if ($urandom_range(3) == 0) begin
        d = $urandom_range(DRV - 1);
        case ($urandom_range(5))
          0, 1, 2, 3: a = 8'($urandom_range(DRV - 1));
          4:          a = 8'hFF;
          default:    a = 8'($urandom_range(255));
        endcase
        add(d, {a, 8'($urandom)});
      end
    end
    repeat (120) tick();
    done = 1'b1;
    repeat (3) tick();
  end
endmodule
